// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter sharing one req/gnt/r_valid memory port among N_PORTS requesters,
// with an in-order routing FIFO for responses. Optional stall counters: MEM_RR_ARBITER_PERF_CNT_EN.
module mem_rr_arbiter #(
   parameter int N_PORTS     = 2,
   parameter int ADDR_WIDTH  = 10,
   parameter int DATA_WIDTH  = 32,
   parameter int BE_WIDTH    = DATA_WIDTH/8,
   parameter int OUTST_DEPTH = 2
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [N_PORTS-1:0]             port_req_i,
   input  logic [N_PORTS*ADDR_WIDTH-1:0]  port_add_i,
   input  logic [N_PORTS-1:0]             port_wen_i,
   input  logic [N_PORTS*DATA_WIDTH-1:0]  port_wdata_i,
   input  logic [N_PORTS*BE_WIDTH-1:0]    port_be_i,
   output logic [N_PORTS-1:0]             port_gnt_o,
   output logic [N_PORTS-1:0]             port_r_valid_o,
   output logic [DATA_WIDTH-1:0]          port_r_rdata_o,
   output logic                           mem_req_o,
   output logic [ADDR_WIDTH-1:0]          mem_add_o,
   output logic                           mem_wen_o,
   output logic [DATA_WIDTH-1:0]          mem_wdata_o,
   output logic [BE_WIDTH-1:0]            mem_be_o,
   input  logic                           mem_gnt_i,
   input  logic                           mem_r_valid_i,
   input  logic [DATA_WIDTH-1:0]          mem_r_rdata_i,
`ifdef MEM_RR_ARBITER_PERF_CNT_EN
   input  logic                           cnt_clr_i,
   output logic [N_PORTS*16-1:0]          stall_cnt_o,
`endif
   output logic                           err_o
);

   localparam int IDX_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
   localparam int PTR_W = (OUTST_DEPTH > 1) ? $clog2(OUTST_DEPTH) : 1;
   localparam int CNT_W = $clog2(OUTST_DEPTH + 1);

   logic [IDX_W-1:0] rr_ptr;
   logic [IDX_W-1:0] winner;
   logic             found;
   logic             active;
   logic [IDX_W-1:0] fifo_q [OUTST_DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [CNT_W-1:0] count;
   logic             full;
   logic             empty;
   logic             push;
   logic             pop;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (int'(p) == OUTST_DEPTH-1) ? '0 : p + 1'b1;
   endfunction

   // Scan from the highest offset down so the port nearest rr_ptr wins last.
   always_comb begin
      int idx;
      idx    = 0;
      winner = '0;
      found  = 1'b0;
      for (int i = N_PORTS-1; i >= 0; i--) begin
         idx = (int'(rr_ptr) + i) % N_PORTS;
         if (port_req_i[idx]) begin
            winner = IDX_W'(idx);
            found  = 1'b1;
         end
      end
   end

   // Outputs are forced quiet while reset is held, not just after the next edge.
   assign active = found & ~reset;
   assign full   = (count == CNT_W'(OUTST_DEPTH));
   assign empty  = (count == '0);
   assign mem_req_o = active & ~full;
   assign push   = mem_req_o & mem_gnt_i;
   assign pop    = mem_r_valid_i & ~empty;
   assign port_r_rdata_o = reset ? '0 : mem_r_rdata_i;

   always_comb begin
      mem_add_o   = '0;
      mem_wen_o   = 1'b0;
      mem_wdata_o = '0;
      mem_be_o    = '0;
      if (active) begin
         mem_add_o   = port_add_i[int'(winner)*ADDR_WIDTH +: ADDR_WIDTH];
         mem_wen_o   = port_wen_i[winner];
         mem_wdata_o = port_wdata_i[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
         mem_be_o    = port_be_i[int'(winner)*BE_WIDTH +: BE_WIDTH];
      end
   end

   always_comb begin
      port_gnt_o     = '0;
      port_r_valid_o = '0;
      if (push)
         port_gnt_o[winner] = 1'b1;
      if (pop)
         port_r_valid_o[fifo_q[rd_ptr]] = 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rr_ptr <= '0;
         count  <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
         err_o  <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= next_ptr(wr_ptr);
            rr_ptr <= (int'(winner) == N_PORTS-1) ? '0 : winner + 1'b1;
         end
         if (pop)
            rd_ptr <= next_ptr(rd_ptr);
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         // A response with nothing outstanding is a protocol violation; latch it.
         if (mem_r_valid_i && empty)
            err_o <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push)
         fifo_q[wr_ptr] <= winner;
   end

`ifdef MEM_RR_ARBITER_PERF_CNT_EN
   logic [15:0] stall_cnt [N_PORTS];

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < N_PORTS; k++)
            stall_cnt[k] <= '0;
      end else if (cnt_clr_i) begin
         for (int k = 0; k < N_PORTS; k++)
            stall_cnt[k] <= '0;
      end else begin
         for (int k = 0; k < N_PORTS; k++)
            if (port_req_i[k] && !port_gnt_o[k])
               stall_cnt[k] <= sat_inc(stall_cnt[k]);
      end
   end

   always_comb begin
      stall_cnt_o = '0;
      for (int k = 0; k < N_PORTS; k++)
         stall_cnt_o[k*16 +: 16] = stall_cnt[k];
   end
`endif

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Directed bench for mem_rr_arbiter (N_PORTS=2, OUTST_DEPTH=2).
module tb_mem_rr_arbiter;

   localparam int N  = 2;
   localparam int AW = 10;
   localparam int DW = 32;
   localparam int BW = 4;

   logic            clk = 1'b0;
   logic            reset = 1'b0;
   logic [N-1:0]    port_req_i = '0;
   logic [N*AW-1:0] port_add_i = '0;
   logic [N-1:0]    port_wen_i = '0;
   logic [N*DW-1:0] port_wdata_i = '0;
   logic [N*BW-1:0] port_be_i = '0;
   logic [N-1:0]    port_gnt_o;
   logic [N-1:0]    port_r_valid_o;
   logic [DW-1:0]   port_r_rdata_o;
   logic            mem_req_o;
   logic [AW-1:0]   mem_add_o;
   logic            mem_wen_o;
   logic [DW-1:0]   mem_wdata_o;
   logic [BW-1:0]   mem_be_o;
   logic            mem_gnt_i = 1'b0;
   logic            mem_r_valid_i = 1'b0;
   logic [DW-1:0]   mem_r_rdata_i = '0;
   logic            err_o;
`ifdef MEM_RR_ARBITER_PERF_CNT_EN
   logic            cnt_clr_i = 1'b0;
   logic [N*16-1:0] stall_cnt_o;
`endif

   int checks = 0;
   int errors = 0;

   mem_rr_arbiter #(.N_PORTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW), .OUTST_DEPTH(2)) dut (
      .clk(clk), .reset(reset),
      .port_req_i(port_req_i), .port_add_i(port_add_i), .port_wen_i(port_wen_i),
      .port_wdata_i(port_wdata_i), .port_be_i(port_be_i),
      .port_gnt_o(port_gnt_o), .port_r_valid_o(port_r_valid_o), .port_r_rdata_o(port_r_rdata_o),
      .mem_req_o(mem_req_o), .mem_add_o(mem_add_o), .mem_wen_o(mem_wen_o),
      .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
      .mem_gnt_i(mem_gnt_i), .mem_r_valid_i(mem_r_valid_i), .mem_r_rdata_i(mem_r_rdata_i),
`ifdef MEM_RR_ARBITER_PERF_CNT_EN
      .cnt_clr_i(cnt_clr_i), .stall_cnt_o(stall_cnt_o),
`endif
      .err_o(err_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [1:0] exp_gnt;
   logic [1:0] prev_gnt;

   initial begin
      // reset with requests present: everything quiet
      port_req_i = 2'b11;
      #2 reset = 1'b1;
      #1;
      check("rst_gnt", 64'(port_gnt_o), 64'h0);
      check("rst_rvalid", 64'(port_r_valid_o), 64'h0);
      check("rst_memreq", 64'(mem_req_o), 64'h0);
      check("rst_err", 64'(err_o), 64'h0);
      check("rst_memadd", 64'(mem_add_o), 64'h0);
      step();
      reset = 1'b0;
      port_req_i = 2'b00;
      step();

      // single load from port 0
      port_add_i[0 +: AW] = 10'h005;
      port_wen_i = 2'b01;
      port_req_i = 2'b01;
      mem_gnt_i  = 1'b1;
      #1;
      check("t1_gnt", 64'(port_gnt_o), 64'h1);
      check("t1_memreq", 64'(mem_req_o), 64'h1);
      check("t1_add", 64'(mem_add_o), 64'h005);
      check("t1_wen", 64'(mem_wen_o), 64'h1);
      step();
      port_req_i = 2'b00;
      mem_gnt_i = 1'b0;
      mem_r_valid_i = 1'b1;
      mem_r_rdata_i = 32'hA5;
      #1;
      check("t1_rvalid", 64'(port_r_valid_o), 64'h1);
      check("t1_rdata", 64'(port_r_rdata_o), 64'hA5);
      check("t1_rrptr", 64'(dut.rr_ptr), 64'h1);
      check("t1_count", 64'(dut.count), 64'h1);
      step();
      mem_r_valid_i = 1'b0;
      #1;
      check("t1_count_after", 64'(dut.count), 64'h0);

      // two ports contend, 1-cycle memory latency; rr_ptr=1 so port 1 goes first
      port_add_i = {10'h022, 10'h011};
      port_wen_i = 2'b01;
      port_wdata_i = {32'hDEADBEEF, 32'h11111111};
      port_be_i = {4'b0011, 4'b1111};
      port_req_i = 2'b11;
      mem_gnt_i = 1'b1;
      prev_gnt = 2'b00;
      for (int k = 0; k < 8; k++) begin
         mem_r_valid_i = (k > 0);
         mem_r_rdata_i = 32'(k);
         exp_gnt = (k % 2 == 0) ? 2'b10 : 2'b01;
         #1;
         check("t2_gnt", 64'(port_gnt_o), 64'(exp_gnt));
         check("t2_add", 64'(mem_add_o), (k % 2 == 0) ? 64'h022 : 64'h011);
         check("t2_wdata", 64'(mem_wdata_o), (k % 2 == 0) ? 64'hDEADBEEF : 64'h11111111);
         check("t2_be", 64'(mem_be_o), (k % 2 == 0) ? 64'h3 : 64'hF);
         check("t2_rvalid", 64'(port_r_valid_o), 64'(prev_gnt));
         prev_gnt = exp_gnt;
         step();
      end
      port_req_i = 2'b00;
      mem_gnt_i = 1'b0;
      mem_r_valid_i = 1'b1;
      #1;
      check("t2_rvalid_last", 64'(port_r_valid_o), 64'h1);
      step();
      mem_r_valid_i = 1'b0;
      #1;
      check("t2_count", 64'(dut.count), 64'h0);
      check("t2_rrptr", 64'(dut.rr_ptr), 64'h1);

`ifdef MEM_RR_ARBITER_PERF_CNT_EN
      cnt_clr_i = 1'b1;
      step();
      cnt_clr_i = 1'b0;
`endif
      // memory stalls for 5 cycles
      port_req_i = 2'b11;
      mem_gnt_i = 1'b0;
      for (int k = 0; k < 5; k++) begin
         #1;
         check("t3_gnt", 64'(port_gnt_o), 64'h0);
         check("t3_memreq", 64'(mem_req_o), 64'h1);
         step();
      end
      check("t3_count", 64'(dut.count), 64'h0);
      check("t3_rrptr", 64'(dut.rr_ptr), 64'h1);
`ifdef MEM_RR_ARBITER_PERF_CNT_EN
      check("t3_stall0", 64'(stall_cnt_o[15:0]), 64'd5);
      check("t3_stall1", 64'(stall_cnt_o[31:16]), 64'd5);
`endif

      // FIFO fills at 2, pop while full does not admit, next cycle does
      mem_gnt_i = 1'b1;
      #1;
      check("t4_gntA", 64'(port_gnt_o), 64'h2);
      step();
      check("t4_gntB", 64'(port_gnt_o), 64'h1);
      step();
      check("t4_count_full", 64'(dut.count), 64'h2);
      check("t4_memreq_full", 64'(mem_req_o), 64'h0);
      mem_r_valid_i = 1'b1;
      mem_r_rdata_i = 32'h77;
      #1;
      check("t4_gnt_full_pop", 64'(port_gnt_o), 64'h0);
      check("t4_rvalid_head", 64'(port_r_valid_o), 64'h2);
      step();
      mem_r_valid_i = 1'b0;
      #1;
      check("t4_count_popped", 64'(dut.count), 64'h1);
      check("t4_memreq_resume", 64'(mem_req_o), 64'h1);
      check("t4_gnt_resume", 64'(port_gnt_o), 64'h2);
      step();
      port_req_i = 2'b00;
      mem_gnt_i = 1'b0;
      mem_r_valid_i = 1'b1;
      #1;
      check("t4_drain0", 64'(port_r_valid_o), 64'h1);
      step();
      check("t4_drain1", 64'(port_r_valid_o), 64'h2);
      step();
      mem_r_valid_i = 1'b0;
      #1;
      check("t4_count_empty", 64'(dut.count), 64'h0);
      check("t4_err_clean", 64'(err_o), 64'h0);

      // stray response with nothing outstanding
      mem_r_valid_i = 1'b1;
      #1;
      check("t5_rvalid", 64'(port_r_valid_o), 64'h0);
      step();
      mem_r_valid_i = 1'b0;
      check("t5_err_set", 64'(err_o), 64'h1);
      step();
      step();
      check("t5_err_sticky", 64'(err_o), 64'h1);

      // reset with two accesses outstanding (rr_ptr now 0)
      port_req_i = 2'b11;
      mem_gnt_i = 1'b1;
      #1;
      check("t6_gnt0", 64'(port_gnt_o), 64'h1);
      step();
      check("t6_gnt1", 64'(port_gnt_o), 64'h2);
      step();
      check("t6_count", 64'(dut.count), 64'h2);
      mem_r_valid_i = 1'b1;
      mem_r_rdata_i = 32'h55;
      reset = 1'b1;
      #1;
      check("t6_gnt", 64'(port_gnt_o), 64'h0);
      check("t6_rvalid", 64'(port_r_valid_o), 64'h0);
      check("t6_memreq", 64'(mem_req_o), 64'h0);
      check("t6_memadd", 64'(mem_add_o), 64'h0);
      check("t6_wdata", 64'(mem_wdata_o), 64'h0);
      check("t6_rdata", 64'(port_r_rdata_o), 64'h0);
      check("t6_err", 64'(err_o), 64'h0);
      port_req_i = 2'b00;
      mem_gnt_i = 1'b0;
      mem_r_valid_i = 1'b0;
      step();
      reset = 1'b0;
      #1;
      check("t6_count_rel", 64'(dut.count), 64'h0);
      check("t6_rrptr_rel", 64'(dut.rr_ptr), 64'h0);
`ifdef MEM_RR_ARBITER_PERF_CNT_EN
      check("t6_stall_rst", 64'(stall_cnt_o), 64'h0);
`endif
      mem_r_valid_i = 1'b1;
      step();
      mem_r_valid_i = 1'b0;
      check("t6_late_resp_err", 64'(err_o), 64'h1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
